// File: rtl/des_key_scheduler_pkg.sv
// Shared constants, types and rotation helpers for the DES key scheduler.
package des_pkg;

   localparam int NUM_ROUNDS = 16;

   localparam logic [1:0] SHIFTS [1:16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   typedef logic [55:0] cd_t;
   typedef logic [47:0] subkey_t;
   typedef logic [27:0] half_t;

   // Rounds outside 1..16 only arise on the final transfer, where the result is discarded.
   function automatic logic [1:0] shift_amt(input logic [4:0] n);
      if (n >= 5'd1 && n <= 5'd16) return SHIFTS[n];
      else                          return 2'd1;
   endfunction

   function automatic half_t rot28l(input half_t x, input logic [1:0] s);
      return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   function automatic half_t rot28r(input half_t x, input logic [1:0] s);
      return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic cd_t rotl_cd(input cd_t cd, input logic [1:0] s);
      return {rot28l(cd[55:28], s), rot28l(cd[27:0], s)};
   endfunction

   function automatic cd_t rotr_cd(input cd_t cd, input logic [1:0] s);
      return {rot28r(cd[55:28], s), rot28r(cd[27:0], s)};
   endfunction

endpackage

// File: rtl/Permuted_Choice_2.sv
// DES Permuted Choice 2: 56-bit C/D to 48-bit round subkey, index 0 = DES bit 1.
module Permuted_Choice_2 (
   input  logic [55:0] cd,
   output logic [47:0] k
);

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   for (genvar j = 0; j < 48; j++) begin : g_pc2
      assign k[j] = cd[PC2_TBL[j] - 1];
   end

   logic unused_cd;
   assign unused_cd = ^{cd[8], cd[17], cd[21], cd[24], cd[34], cd[37], cd[42], cd[53]};

endmodule

// File: rtl/des_key_scheduler_pc1.sv
// DES Permuted Choice 1: 64-bit key to 56-bit C/D, index 0 = DES bit 1.
module des_pc1 (
   input  logic [63:0] key_in,
   output logic [55:0] cd
);

   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   for (genvar j = 0; j < 56; j++) begin : g_pc1
      assign cd[j] = key_in[PC1_TBL[j] - 1];
   end

   // Parity bits (DES bits 8, 16, ..., 64) are dropped by PC-1.
   logic unused_parity;
   assign unused_parity = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                            key_in[39], key_in[47], key_in[55], key_in[63]};

endmodule

// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: PC-1 load, 16 C/D rotations, PC-2 subkeys over valid/ready.
// Optional reverse (decrypt) order is built when DES_KEYSCHED_DECRYPT_EN is defined.
module des_key_scheduler
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        decrypt,
   input  logic [63:0] key_in,
   input  logic        abort,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round_idx,
   output logic        busy,
   output logic        done
);

   state_t state;
   cd_t    cd;
   cd_t    pc1_out;
   cd_t    cd_load;
   cd_t    cd_step;
   logic   xfer;

   des_pc1 u_pc1 (
      .key_in (key_in),
      .cd     (pc1_out)
   );

   Permuted_Choice_2 u_pc2 (
      .cd (cd),
      .k  (subkey)
   );

   assign xfer = subkey_valid & subkey_ready;

`ifdef DES_KEYSCHED_DECRYPT_EN
   logic dec_q;

   // Unrotated PC-1 output already equals C16/D16, so decrypt starts from it directly.
   always_comb begin
      cd_load = decrypt ? pc1_out : rotl_cd(pc1_out, shift_amt(5'd1));
      cd_step = dec_q ? rotr_cd(cd, shift_amt(5'd16 - {1'b0, round_idx}))
                      : rotl_cd(cd, shift_amt({1'b0, round_idx} + 5'd2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           dec_q <= 1'b0;
      else if (state == IDLE && start && !abort) dec_q <= decrypt;
   end
`else
   logic unused_decrypt;
   assign unused_decrypt = decrypt;

   always_comb begin
      cd_load = rotl_cd(pc1_out, shift_amt(5'd1));
      cd_step = rotl_cd(cd, shift_amt({1'b0, round_idx} + 5'd2));
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cd           <= '0;
         round_idx    <= '0;
         subkey_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else if (abort) begin
         state        <= IDLE;
         subkey_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  cd           <= cd_load;
                  round_idx    <= '0;
                  subkey_valid <= 1'b1;
                  busy         <= 1'b1;
                  state        <= ROUND;
               end
            end
            ROUND: begin
               if (xfer) begin
                  if (round_idx == 4'(NUM_ROUNDS - 1)) begin
                     subkey_valid <= 1'b0;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     state        <= DONE;
                  end else begin
                     round_idx <= round_idx + 4'd1;
                     cd        <= cd_step;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler against a bit-level DES key schedule model.
module tb_des_key_scheduler;

`ifdef DES_KEYSCHED_DECRYPT_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        decrypt;
   logic [63:0] key_in;
   logic        abort;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [3:0]  round_idx;
   logic        busy;
   logic        done;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [47:0] exp_k [16];
   logic [47:0] got   [16];
   logic [47:0] enc   [16];
   logic [63:0] test_key;

   always #5 clk = ~clk;

   des_key_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .decrypt      (decrypt),
      .key_in       (key_in),
      .abort        (abort),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .round_idx    (round_idx),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [47:0] r48(input logic [47:0] v);
      logic [47:0] r;
      for (int i = 0; i < 48; i++) r[i] = v[47 - i];
      return r;
   endfunction

   function automatic logic [63:0] r64(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = v[63 - i];
      return r;
   endfunction

   // Textbook schedule: C/D as bit arrays in DES numbering, left shifts, PC-2 per round.
   task automatic build_exp(input logic [63:0] key, input bit reverse);
      bit          c [28];
      bit          d [28];
      bit          cn [28];
      bit          dn [28];
      logic [47:0] k [16];
      for (int i = 0; i < 28; i++) begin
         c[i] = key[PC1[i] - 1];
         d[i] = key[PC1[28 + i] - 1];
      end
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i < 28; i++) begin
            cn[i] = c[(i + SH[r]) % 28];
            dn[i] = d[(i + SH[r]) % 28];
         end
         c = cn;
         d = dn;
         for (int j = 0; j < 48; j++)
            k[r][j] = (PC2[j] <= 28) ? c[PC2[j] - 1] : d[PC2[j] - 29];
      end
      for (int r = 0; r < 16; r++) exp_k[r] = reverse ? k[15 - r] : k[r];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_schedule(input logic [63:0] key, input bit dec, input bit bp, input bit noise);
      int          cnt = 0;
      int          cyc = 0;
      bit          hold = 1'b0;
      bit          fin = 1'b0;
      logic [47:0] hk = '0;
      logic [3:0]  hi = '0;
      build_exp(key, dec && DEC_EN);
      start        = 1'b1;
      key_in       = key;
      decrypt      = dec;
      subkey_ready = 1'b1;
      tick();
      start   = 1'b0;
      key_in  = {$urandom, $urandom};
      decrypt = ~dec;
      while (!fin && cyc < 400) begin
         cyc++;
         if (done) begin
            chk("transfer_count", 64'(cnt), 64'd16);
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("valid_at_done", 64'(subkey_valid), 64'd0);
            if (!bp) chk("done_cycle", 64'(cyc), 64'd17);
            fin = 1'b1;
         end else begin
            if (hold) begin
               chk("hold_subkey", 64'(subkey), 64'(hk));
               chk("hold_round_idx", 64'(round_idx), 64'(hi));
            end
            chk("valid_in_round", 64'(subkey_valid), 64'd1);
            chk("busy_in_round", 64'(busy), 64'd1);
            subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (subkey_valid && subkey_ready) begin
               if (cnt < 16) begin
                  chk("round_idx", 64'(round_idx), 64'(cnt));
                  chk("subkey", 64'(subkey), 64'(exp_k[cnt]));
                  got[cnt] = subkey;
               end else begin
                  chk("extra_transfer", 64'(cnt), 64'd15);
               end
               cnt++;
               hold = 1'b0;
            end else begin
               hold = subkey_valid;
               hk   = subkey;
               hi   = round_idx;
            end
            if (noise) begin
               start   = 1'($urandom_range(0, 1));
               key_in  = {$urandom, $urandom};
               decrypt = 1'($urandom_range(0, 1));
            end
            tick();
         end
      end
      if (!fin) chk("done_timeout", 64'd0, 64'd1);
      start        = 1'b0;
      subkey_ready = 1'b1;
      tick();
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      decrypt      = 1'b0;
      key_in       = '0;
      abort        = 1'b0;
      subkey_ready = 1'b0;
      test_key     = r64(64'h133457799BBCDFF1);
      tick();
      chk("rst_valid", 64'(subkey_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_round_idx", 64'(round_idx), 64'd0);
      chk("rst_subkey", 64'(subkey), 64'd0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_no_start", 64'(busy), 64'd0);

      // Encrypt, known-answer key, ready held high
      run_schedule(test_key, 1'b0, 1'b0, 1'b0);
      chk("kat_K1", 64'(got[0]), 64'(r48(48'h1B02EFFC7072)));
      chk("kat_K2", 64'(got[1]), 64'(r48(48'h79AED9DBC9E5)));
      chk("kat_K16", 64'(got[15]), 64'(r48(48'hCB3D8B0E17F5)));
      for (int i = 0; i < 16; i++) enc[i] = got[i];

      // Decrypt order (forward order when reverse support is not built)
      run_schedule(test_key, 1'b1, 1'b0, 1'b0);
      chk("dec_first", 64'(got[0]), 64'(DEC_EN ? r48(48'hCB3D8B0E17F5) : r48(48'h1B02EFFC7072)));
      chk("dec_last", 64'(got[15]), 64'(DEC_EN ? r48(48'h1B02EFFC7072) : r48(48'hCB3D8B0E17F5)));
      for (int i = 0; i < 16; i++)
         chk("dec_vs_enc", 64'(got[i]), 64'(DEC_EN ? enc[15 - i] : enc[i]));

      // Backpressure with the known key, then random keys in both modes
      run_schedule(test_key, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) chk("bp_vs_enc", 64'(got[i]), 64'(enc[i]));
      for (int n = 0; n < 3; n++) begin
         run_schedule({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
         run_schedule({$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
      end

      // start pulses with other keys during the schedule are ignored
      run_schedule(test_key, 1'b0, 1'b0, 1'b1);
      run_schedule({$urandom, $urandom}, 1'b1, 1'b1, 1'b1);

      // Abort at round 7 with ready high
      start   = 1'b1;
      key_in  = test_key;
      decrypt = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("abort_at_idx", 64'(round_idx), 64'd7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", 64'(subkey_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("abort_no_done", 64'(done), 64'd0);
         tick();
      end
      run_schedule(test_key, 1'b0, 1'b0, 1'b0);
      chk("after_abort_K1", 64'(got[0]), 64'(r48(48'h1B02EFFC7072)));

      // abort beats start in IDLE
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start", 64'(busy), 64'd0);
      chk("abort_beats_start_v", 64'(subkey_valid), 64'd0);

      // Asynchronous reset in the middle of a schedule
      start  = 1'b1;
      key_in = test_key;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(subkey_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_round_idx", 64'(round_idx), 64'd0);
      chk("arst_subkey", 64'(subkey), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_busy", 64'(busy), 64'd0);
         chk("post_rst_valid", 64'(subkey_valid), 64'd0);
      end
      run_schedule(test_key, 1'b0, 1'b0, 1'b0);
      chk("post_rst_K1", 64'(got[0]), 64'(r48(48'h1B02EFFC7072)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
